// File: rtl/mult_pkg.sv
// Shared definitions for the approximate multiplier datapath.
// Product width and accumulate-stage state encoding.
package mult_pkg;

    localparam int PROD_W = 32;

    typedef enum logic {
        ACC,
        HOLD
    } acc_state_t;

endpackage

// File: rtl/mult_acc_stage_if.sv
// Product-in / result-out handshake bundle for mult_acc_stage.
// slave = the accumulator, master = the block driving it.
interface mult_acc_stage_if #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 4
);
    import mult_pkg::*;

    logic [PROD_W-1:0] p_in;
    logic              p_valid;
    logic              p_ready;
    logic              flush;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_ovf;
    logic              acc_valid;
    logic              acc_ready;

    modport slave (
        input  p_in,
        input  p_valid,
        output p_ready,
        input  flush,
        output acc_out,
        output acc_count,
        output acc_ovf,
        output acc_valid,
        input  acc_ready
    );

    modport master (
        output p_in,
        output p_valid,
        input  p_ready,
        output flush,
        input  acc_out,
        input  acc_count,
        input  acc_ovf,
        input  acc_valid,
        output acc_ready
    );

endinterface

// File: rtl/mult_acc_stage.sv
// Accumulates LEN unsigned products into a wide sum and hands the
// group total (sum, count, overflow) downstream over valid/ready.
module mult_acc_stage
    import mult_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 40,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    mult_acc_stage_if.slave  bus
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;

    logic             in_acc;
    logic             accept;
    logic             close;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] add_sum;
    logic [CNT_W-1:0] add_cnt;
    logic             add_ovf;

    // Handshake outputs decode from state; reset masks p_ready.
    always_comb begin
        in_acc        = (state_q == ACC);
        bus.p_ready   = in_acc & ~rst;
        bus.acc_valid = (state_q == HOLD);
        bus.acc_out   = out_q;
        bus.acc_count = ocnt_q;
        bus.acc_ovf   = oovf_q;
    end

    // Running-sum update: one ACC_W+1 add, top bit is the carry.
    always_comb begin
        accept  = bus.p_valid & bus.p_ready;
        sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(bus.p_in);
        add_sum = sum_q;
        add_cnt = cnt_q;
        add_ovf = ovf_q;
        if (accept) begin
            add_sum = sum_ext[ACC_W-1:0];
            add_cnt = cnt_q + CNT_W'(1);
            add_ovf = ovf_q | sum_ext[ACC_W];
        end
    end

    // Group closes on the LEN-th product or a non-empty flush.
    always_comb begin
        close = 1'b0;
        if (in_acc) begin
            if (accept && (cnt_q == CNT_W'(LEN - 1)))
                close = 1'b1;
            if (bus.flush && ((cnt_q != '0) || accept))
                close = 1'b1;
        end
    end

    // Next-state selection for the FSM and result registers.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        unique case (state_q)
            ACC: begin
                if (close) begin
                    out_d   = add_sum;
                    ocnt_d  = add_cnt;
                    oovf_d  = add_ovf;
                    sum_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = HOLD;
                end else begin
                    sum_d = add_sum;
                    cnt_d = add_cnt;
                    ovf_d = add_ovf;
                end
            end
            HOLD: begin
                if (bus.acc_ready)
                    state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Directed bench for mult_acc_stage: a LEN=8 / ACC_W=40 instance and
// a LEN=8 / ACC_W=33 instance driven in lockstep with the same stimulus.
module tb_mult_acc_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mult_acc_stage_if #(.ACC_W(40), .CNT_W(4)) b40 ();
    mult_acc_stage_if #(.ACC_W(33), .CNT_W(4)) b33 ();

    mult_acc_stage #(.LEN(8), .ACC_W(40), .CNT_W(4)) u40 (
        .clk (clk),
        .rst (rst),
        .bus (b40.slave)
    );

    mult_acc_stage #(.LEN(8), .ACC_W(33), .CNT_W(4)) u33 (
        .clk (clk),
        .rst (rst),
        .bus (b33.slave)
    );

    task automatic drive(input logic [31:0] v, input logic pv, input logic fl);
        b40.p_in = v;  b40.p_valid = pv;  b40.flush = fl;
        b33.p_in = v;  b33.p_valid = pv;  b33.flush = fl;
    endtask

    task automatic ardy(input logic r);
        b40.acc_ready = r;
        b33.acc_ready = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] v, input logic fl);
        drive(v, 1'b1, fl);
        tick();
        drive(32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        ardy(1'b1);
        tick();
        tick();
        n_cmp++; if (b40.p_ready !== 1'b0) begin n_err++; $display("FAIL rst_p_ready got %0b want 0", b40.p_ready); end
        n_cmp++; if (b40.acc_valid !== 1'b0) begin n_err++; $display("FAIL rst_acc_valid got %0b want 0", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd0) begin n_err++; $display("FAIL rst_acc_out got %0h want 0", b40.acc_out); end
        n_cmp++; if (b40.acc_count !== 4'd0) begin n_err++; $display("FAIL rst_acc_count got %0d want 0", b40.acc_count); end
        n_cmp++; if (b40.acc_ovf !== 1'b0) begin n_err++; $display("FAIL rst_acc_ovf got %0b want 0", b40.acc_ovf); end
        n_cmp++; if (b33.acc_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf33 got %0b want 0", b33.acc_ovf); end
        rst = 1'b0;
        #1;
        n_cmp++; if (b40.p_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %0b want 1", b40.p_ready); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lows;
        lows = 0;
        ardy(1'b1);
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (b40.p_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, b40.p_ready); end
            push(32'(i), 1'b0);
        end
        n_cmp++; if (b40.acc_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %0b want 1", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd36) begin n_err++; $display("FAIL b2b_out got %0d want 36", b40.acc_out); end
        n_cmp++; if (b40.acc_count !== 4'd8) begin n_err++; $display("FAIL b2b_count got %0d want 8", b40.acc_count); end
        n_cmp++; if (b40.acc_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %0b want 0", b40.acc_ovf); end
        for (int k = 0; k < 3; k++) begin
            if (b40.p_ready === 1'b0) lows++;
            tick();
        end
        n_cmp++; if (lows !== 1) begin n_err++; $display("FAIL b2b_bubble got %0d want 1", lows); end
        n_cmp++; if (b40.acc_valid !== 1'b0) begin n_err++; $display("FAIL b2b_handoff got %0b want 0", b40.acc_valid); end
    endtask

    task automatic test_overflow();
        ardy(1'b1);
        for (int i = 0; i < 8; i++) push(32'hFFFF_FFFF, 1'b0);
        n_cmp++; if (b40.acc_out !== 40'h7_FFFF_FFF8) begin n_err++; $display("FAIL ovf40_out got %0h want 7fffffff8", b40.acc_out); end
        n_cmp++; if (b40.acc_count !== 4'd8) begin n_err++; $display("FAIL ovf40_count got %0d want 8", b40.acc_count); end
        n_cmp++; if (b40.acc_ovf !== 1'b0) begin n_err++; $display("FAIL ovf40_flag got %0b want 0", b40.acc_ovf); end
        n_cmp++; if (b33.acc_out !== 33'h1_FFFF_FFF8) begin n_err++; $display("FAIL ovf33_out got %0h want 1fffffff8", b33.acc_out); end
        n_cmp++; if (b33.acc_ovf !== 1'b1) begin n_err++; $display("FAIL ovf33_flag got %0b want 1", b33.acc_ovf); end
        tick();
        for (int i = 1; i <= 8; i++) push(32'(i), 1'b0);
        n_cmp++; if (b33.acc_out !== 33'd36) begin n_err++; $display("FAIL ovf33_next_out got %0h want 24", b33.acc_out); end
        n_cmp++; if (b33.acc_ovf !== 1'b0) begin n_err++; $display("FAIL ovf33_next_flag got %0b want 0", b33.acc_ovf); end
        tick();
    endtask

    task automatic test_flush();
        ardy(1'b1);
        push(32'd5, 1'b0);
        push(32'd7, 1'b0);
        drive(32'd0, 1'b0, 1'b1);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        n_cmp++; if (b40.acc_valid !== 1'b1) begin n_err++; $display("FAIL flush_valid got %0b want 1", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd12) begin n_err++; $display("FAIL flush_out got %0d want 12", b40.acc_out); end
        n_cmp++; if (b40.acc_count !== 4'd2) begin n_err++; $display("FAIL flush_count got %0d want 2", b40.acc_count); end
        tick();
        drive(32'd0, 1'b0, 1'b1);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        n_cmp++; if (b40.acc_valid !== 1'b0) begin n_err++; $display("FAIL empty_flush_valid got %0b want 0", b40.acc_valid); end
        n_cmp++; if (b40.p_ready !== 1'b1) begin n_err++; $display("FAIL empty_flush_ready got %0b want 1", b40.p_ready); end
        tick();
        n_cmp++; if (b40.acc_valid !== 1'b0) begin n_err++; $display("FAIL empty_flush_valid2 got %0b want 0", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd12) begin n_err++; $display("FAIL empty_flush_hold got %0d want 12", b40.acc_out); end
        push(32'd5, 1'b0);
        push(32'd7, 1'b0);
        push(32'd3, 1'b1);
        n_cmp++; if (b40.acc_valid !== 1'b1) begin n_err++; $display("FAIL flush_acc_valid got %0b want 1", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd15) begin n_err++; $display("FAIL flush_acc_out got %0d want 15", b40.acc_out); end
        n_cmp++; if (b40.acc_count !== 4'd3) begin n_err++; $display("FAIL flush_acc_count got %0d want 3", b40.acc_count); end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        ardy(1'b0);
        for (int i = 1; i <= 8; i++) push(32'(i), 1'b0);
        n_cmp++; if (b40.acc_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %0b want 1", b40.acc_valid); end
        drive(32'd100, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (b40.p_ready !== 1'b0 || b40.acc_valid !== 1'b1 ||
                b40.acc_out !== 40'd36 || b40.acc_count !== 4'd8) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold_cycles got %0d bad want 0", bad); end
        ardy(1'b1);
        tick();
        n_cmp++; if (b40.p_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %0b want 1", b40.p_ready); end
        n_cmp++; if (b40.acc_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got %0b want 0", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd36) begin n_err++; $display("FAIL bp_release_out got %0d want 36", b40.acc_out); end
        tick();
        drive(32'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) push(32'(i), 1'b0);
        n_cmp++; if (b40.acc_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid got %0b want 1", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd128) begin n_err++; $display("FAIL bp_next_out got %0d want 128", b40.acc_out); end
        n_cmp++; if (b40.acc_count !== 4'd8) begin n_err++; $display("FAIL bp_next_count got %0d want 8", b40.acc_count); end
        tick();
    endtask

    task automatic test_mid_reset();
        ardy(1'b1);
        for (int i = 0; i < 3; i++) push(32'd9, 1'b0);
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (b40.p_ready !== 1'b0) begin n_err++; $display("FAIL mrst_ready got %0b want 0", b40.p_ready); end
        tick();
        n_cmp++; if (b40.acc_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %0b want 0", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd0) begin n_err++; $display("FAIL mrst_out got %0d want 0", b40.acc_out); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push(32'd2, 1'b0);
        n_cmp++; if (b40.acc_valid !== 1'b1) begin n_err++; $display("FAIL mrst_grp_valid got %0b want 1", b40.acc_valid); end
        n_cmp++; if (b40.acc_out !== 40'd16) begin n_err++; $display("FAIL mrst_grp_out got %0d want 16", b40.acc_out); end
        n_cmp++; if (b40.acc_count !== 4'd8) begin n_err++; $display("FAIL mrst_grp_count got %0d want 8", b40.acc_count); end
        n_cmp++; if (b40.acc_ovf !== 1'b0) begin n_err++; $display("FAIL mrst_grp_ovf got %0b want 0", b40.acc_ovf); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        ardy(1'b1);
        tick();
        test_reset();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_backpressure();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_acc_stage.md
# mult_acc_stage

Downstream consumer of the 16x16 approximate multiplier wrapper. It accepts one registered 32-bit unsigned product per cycle over a valid/ready handshake and accumulates LEN products into a wide sum. It then presents the group result (sum, product count, overflow flag) on a second valid/ready handshake. Use: dot-product and error-statistics runs over the approximate multiplier.

## Interface
- LEN, default 8: number of products per group; legal range 1..255.
- ACC_W, default 40: accumulator width; must be ≥ 32.
- CNT_W, default $clog2(LEN+1): width of the product count.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- p_in  in  32  unsigned product from the multiplier output register.
- p_valid  in  1  p_in is valid this cycle.
- p_ready  out  1  stage accepts a product this cycle.
- flush  in  1  close the current group early; sampled only while p_ready=1.
- acc_out  out  ACC_W  group sum, modulo 2^ACC_W.
- acc_count  out  CNT_W  number of products in acc_out.
- acc_ovf  out  1  sticky flag: the group sum wrapped past 2^ACC_W.
- acc_valid  out  1  result is valid.
- acc_ready  in  1  downstream accepts the result.

## Operation
- Two states:
  - ACC: collecting products; p_ready=1.
  - HOLD: result presented; p_ready=0, acc_valid=1.
- Product accept: p_valid && p_ready.
  - Add p_in zero-extended to ACC_W into the running sum.
  - Increment the running count.
  - Carry out of bit ACC_W-1 sets the running overflow bit.
- Group close, in ACC, occurs when either:
  - a product is accepted that makes the count reach LEN; or
  - flush=1 while the running count is nonzero, or while a product is accepted in the same cycle.
- On group close:
  - acc_out, acc_count and acc_ovf load the totals, including any product accepted that cycle.
  - Running sum, count and overflow clear to 0.
  - State goes to HOLD.
- flush=1 with count=0 and no accept: ignored. No empty groups are emitted.
- flush in HOLD: ignored; it is not remembered.
- Result handoff: in HOLD, acc_valid && acc_ready returns the state to ACC. acc_out, acc_count and acc_ovf hold their values until the next group close.
- acc_out, acc_count and acc_ovf stay stable throughout HOLD.
- Back-pressure: products offered during HOLD are not accepted. The upstream must hold p_in/p_valid.

## Timing
- Reset values:
  - state = ACC; running sum, count and overflow = 0.
  - acc_out = 0, acc_count = 0, acc_ovf = 0, acc_valid = 0.
  - p_ready = 0 while rst=1, and 1 in the first cycle after rst deasserts.
- p_ready and acc_valid are decoded from state only. There is no combinational path from p_valid, flush or acc_ready to any output.
- Latency: group-closing accept at edge t gives acc_valid=1 in the cycle after edge t.
- Handoff at edge t gives p_ready=1 after edge t. Minimum bubble is one cycle per group, so throughput is LEN products per LEN+1 cycles when acc_ready is tied high.
- acc_valid may stay high indefinitely; no timeout.
- rst mid-group or in HOLD: the partial group and any pending result are discarded. All reset values apply at the next edge.

## Structure
- Shared package mult_pkg holds:
  - PROD_W = 32 (multiplier product width, shared with the multiplier wrapper).
  - acc_state_t enum {ACC, HOLD}.
- Single module; no sub-module is warranted. The adder is one ACC_W+1-bit add whose top bit is the carry.

## Test plan
- LEN=8, ACC_W=40, acc_ready=1, products 1..8 back-to-back:
  - acc_valid pulses one cycle after the 8th accept, with acc_out=36, acc_count=8, acc_ovf=0.
  - p_ready is low for exactly one cycle.
- LEN=8; 8 products of 0xFFFF_FFFF:
  - acc_out=0x7_FFFF_FFF8, acc_count=8, acc_ovf=0.
  - Rerun with ACC_W=33: acc_out=0x1_FFFF_FFF8 (mod 2^33), acc_ovf=1.
  - The following group has acc_ovf=0.
- Products 5, 7, then flush=1 with p_valid=0:
  - acc_out=12, acc_count=2.
  - flush with count=0 produces no acc_valid.
  - flush together with an accepted product 3 after 5 and 7: acc_out=15, acc_count=3.
- acc_ready held low for 10 cycles after a group close:
  - p_ready stays 0 and acc_out/acc_count stay constant.
  - The held p_in is accepted in the cycle after the handoff, and the next sum is correct.
- rst asserted after 3 accepted products, then 8 products of value 2:
  - acc_out=16, acc_count=8. No contribution from before the reset.
